// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line in, received byte with strobes and status out
interface uart_receiver_if;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;
  modport master (output rx_i, input data_o, valid_o, frame_err_o, busy_o);
  modport slave  (input rx_i, output data_o, valid_o, frame_err_o, busy_o);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver, mid-bit sampling, framing error detection
module uart_receiver #(
  parameter int CLKS_PER_BIT = 868
) (
  input logic         clk,
  input logic         rst,
  uart_receiver_if.slave bus
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [18:0] HALF_LAST = 19'(HALF_BIT - 1);
  localparam logic [18:0] BIT_LAST = 19'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t      state_q, state_d;
  logic        rx_m_q, rx_s_q, rx_d_q;
  logic [18:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d, data_q, data_d;
  logic        valid_q, valid_d, ferr_q, ferr_d;
  logic        fall, bit_end;
  assign fall = rx_d_q & ~rx_s_q;
  assign bit_end = timer_q == BIT_LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      {rx_m_q, rx_s_q, rx_d_q} <= 3'b111;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      {rx_m_q, rx_s_q, rx_d_q} <= {bus.rx_i, rx_m_q, rx_s_q};
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  // A low stop bit parks in BRK so a held-low line yields a single error
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 19'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        state_d = fall ? START : IDLE;
      end
      START: if (timer_q == HALF_LAST) begin
        state_d = rx_s_q ? IDLE : DATA;
        timer_d = '0;
        idx_d   = '0;
      end
      DATA: if (bit_end) begin
        shift_d[idx_q] = rx_s_q;
        timer_d = '0;
        idx_d   = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        timer_d = '0;
        state_d = rx_s_q ? IDLE : BRK;
        valid_d = rx_s_q;
        ferr_d  = ~rx_s_q;
        data_d  = rx_s_q ? shift_q : data_q;
      end
      BRK: if (rx_s_q) begin
        state_d = IDLE;
        timer_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.frame_err_o = ferr_q;
  assign bus.busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized 8N1 frames checked against a byte-queue model
`timescale 1ns/1ps
module tb_uart_receiver;
  localparam int CPB = 16;
  localparam realtime BIT = 160.0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_receiver_if bus();
  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int busy_cycles = 0;
  realtime t_valid = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int checks = 0;
  int fails = 0;
  always @(negedge clk) begin
    if (bus.valid_o) begin
      n_valid <= n_valid + 1;
      rx_q.push_back(bus.data_o);
      t_valid <= $realtime;
    end
    if (bus.frame_err_o) n_err <= n_err + 1;
    if (bus.valid_o && bus.frame_err_o) n_both <= n_both + 1;
    if (bus.busy_o) busy_cycles <= busy_cycles + 1;
  end
  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input realtime p);
    bus.rx_i = v;
    #(p);
  endtask
  task automatic send(input logic [7:0] b, input realtime p, input logic stop);
    drive(1'b0, p);
    for (int i = 0; i < 8; i++) drive(b[i], p);
    drive(stop, p);
  endtask
  task automatic wait_valid(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && n_valid < target; i++) @(negedge clk);
    #1;
    chk(tag, n_valid, target);
  endtask
  initial begin
    logic [7:0] b;
    realtime t0, p;
    int lat, bc, sel;
    bus.rx_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.data_o, 8'h00);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_ferr", bus.frame_err_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    @(negedge clk);
    t0 = $realtime;
    send(8'hA5, BIT, 1'b1);
    wait_valid(1, 400, "a5_count");
    lat = int'((t_valid - t0) / 10.0);
    chk("a5_latency_in_range", (lat >= 153 && lat <= 157), 1);
    chk("a5_data", rx_q[0], 8'hA5);
    chk("a5_no_err", n_err, 0);
    send(8'h00, BIT, 1'b1);
    send(8'hFF, BIT, 1'b1);
    send(8'h55, BIT, 1'b1);
    wait_valid(4, 400, "b2b_count");
    chk("b2b_0", rx_q[1], 8'h00);
    chk("b2b_1", rx_q[2], 8'hFF);
    chk("b2b_2", rx_q[3], 8'h55);
    chk("b2b_no_err", n_err, 0);
    repeat (20) @(negedge clk);
    #1;
    bc = busy_cycles;
    bus.rx_i = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx_i = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    bc = busy_cycles - bc;
    chk("glitch_busy_window", (bc >= 6 && bc <= 10), 1);
    chk("glitch_busy_low", bus.busy_o, 0);
    chk("glitch_no_valid", n_valid, 4);
    chk("glitch_no_err", n_err, 0);
    send(8'h3C, BIT, 1'b0);
    drive(1'b0, 40 * BIT);
    bus.rx_i = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    #1;
    chk("break_one_err", n_err, 1);
    chk("break_no_valid", n_valid, 4);
    chk("break_data_held", bus.data_o, 8'h55);
    chk("break_idle", bus.busy_o, 0);
    send(8'h81, BIT, 1'b1);
    wait_valid(5, 400, "after_break_count");
    chk("after_break_data", rx_q[4], 8'h81);
    @(negedge clk);
    b = 8'hC3;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(b[i], BIT);
    #(BIT / 2);
    @(negedge clk);
    rst = 1'b1;
    bus.rx_i = 1'b1;
    @(negedge clk);
    chk("abort_data", bus.data_o, 8'h00);
    chk("abort_valid", bus.valid_o, 0);
    chk("abort_ferr", bus.frame_err_o, 0);
    chk("abort_busy", bus.busy_o, 0);
    rst = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    #1;
    chk("abort_no_valid", n_valid, 5);
    chk("abort_no_err", n_err, 1);
    send(8'h12, BIT, 1'b1);
    wait_valid(6, 400, "after_abort_count");
    chk("after_abort_data", rx_q[5], 8'h12);
    chk("after_abort_out", bus.data_o, 8'h12);
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 2));
      p = sel == 0 ? BIT * 0.97 : sel == 1 ? BIT : BIT * 1.03;
      exp_q.push_back(b);
      send(b, p, 1'b1);
    end
    wait_valid(6 + 256, 2000, "loop_count");
    for (int i = 0; i < 256; i++) chk($sformatf("loop_byte_%0d", i), rx_q[6 + i], exp_q[i]);
    chk("loop_no_err", n_err, 1);
    chk("never_both", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
